// File: rtl/camera_pattern_tx.sv
// rtl/camera_pattern_tx.sv - OV7670-style RGB565 test pattern camera emulator
module camera_pattern_tx #(
    parameter int PCLK_DIV = 2,
    parameter int H_ACTIVE = 320,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 240,
    parameter int V_FRONT  = 10
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic [1:0]  mode_in,
    input  logic [15:0] solid_color_in,
    output logic        pclk_out,
    output logic        vsync_out,
    output logic        href_out,
    output logic [7:0]  pixel_out,
    output logic        frame_done_out,
    output logic [7:0]  frame_count_out
);

    localparam int DIV_W = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCLK_DIV - 1);
    localparam logic [15:0] COL_LAST   = 16'(2 * H_ACTIVE + H_BLANK - 1);
    localparam logic [15:0] HREF_END   = 16'(2 * H_ACTIVE);
    localparam logic [15:0] HREF_LAST  = 16'(2 * H_ACTIVE - 1);
    localparam logic [15:0] SYNC_LAST  = 16'(V_SYNC - 1);
    localparam logic [15:0] BACK_LAST  = 16'(V_BACK - 1);
    localparam logic [15:0] ACT_LAST   = 16'(V_ACTIVE - 1);
    localparam logic [15:0] FRONT_LAST = 16'(V_FRONT - 1);
    localparam logic [15:0] BAR_W      = 16'((H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    state_t             r_state, w_state_nxt;
    logic [DIV_W-1:0]   r_div;
    logic [15:0]        r_col, r_line, w_col_nxt, w_line_nxt;
    logic [1:0]         r_mode;
    logic [15:0]        r_color;
    logic               w_fall, w_latch, w_done, w_href_nxt;
    logic [15:0]        w_x, w_bar, w_pix16;
    logic [7:0]         w_byte_nxt;

    // All frame timing advances only on the clk_in edge where pclk falls.
    assign w_fall = pclk_out && (r_div == DIV_LAST);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_div    <= '0;
            pclk_out <= 1'b0;
        end else if (r_div == DIV_LAST) begin
            r_div    <= '0;
            pclk_out <= ~pclk_out;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_line  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_line  <= w_line_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_line_nxt  = r_line;
        w_latch     = 1'b0;
        w_done      = 1'b0;
        if (w_fall) begin
            if (r_state == IDLE) begin
                if (enable_in) begin
                    w_state_nxt = VSYNC;
                    w_col_nxt   = '0;
                    w_line_nxt  = '0;
                    w_latch     = 1'b1;
                end
            end else begin
                w_done = (r_state == ACTIVE) && (r_line == ACT_LAST) && (r_col == HREF_LAST);
                if (r_col != COL_LAST) begin
                    w_col_nxt = r_col + 16'd1;
                end else begin
                    w_col_nxt  = '0;
                    w_line_nxt = r_line + 16'd1;
                    case (r_state)
                        VSYNC: if (r_line == SYNC_LAST) begin
                            w_state_nxt = VBACK;
                            w_line_nxt  = '0;
                        end
                        VBACK: if (r_line == BACK_LAST) begin
                            w_state_nxt = ACTIVE;
                            w_line_nxt  = '0;
                        end
                        ACTIVE: if (r_line == ACT_LAST) begin
                            w_state_nxt = VFRONT;
                            w_line_nxt  = '0;
                        end
                        VFRONT: if (r_line == FRONT_LAST) begin
                            w_line_nxt = '0;
                            if (enable_in) begin
                                w_state_nxt = VSYNC;
                                w_latch     = 1'b1;
                            end else begin
                                w_state_nxt = IDLE;
                            end
                        end
                        default: w_state_nxt = IDLE;
                    endcase
                end
            end
        end
    end

    // Pixel colour for the position about to be presented (next column/line).
    assign w_x   = {1'b0, w_col_nxt[15:1]};
    assign w_bar = w_x / BAR_W;

    always_comb begin
        w_pix16 = 16'h0000;
        case (r_mode)
            2'd0: begin
                case (w_bar)
                    16'd0:   w_pix16 = 16'hFFFF;
                    16'd1:   w_pix16 = 16'hFFE0;
                    16'd2:   w_pix16 = 16'h07FF;
                    16'd3:   w_pix16 = 16'h07E0;
                    16'd4:   w_pix16 = 16'hF81F;
                    16'd5:   w_pix16 = 16'hF800;
                    16'd6:   w_pix16 = 16'h001F;
                    default: w_pix16 = 16'h0000;
                endcase
            end
            2'd1:    w_pix16 = r_color;
            2'd2:    w_pix16 = {w_x[7:3], w_line_nxt[7:2], ~w_x[7:3]};
            default: w_pix16 = (w_x[4] ^ w_line_nxt[4]) ? 16'hFFFF : 16'h0000;
        endcase
    end

    assign w_href_nxt = (w_state_nxt == ACTIVE) && (w_col_nxt < HREF_END);
    assign w_byte_nxt = !w_href_nxt ? 8'h00 : (w_col_nxt[0] ? w_pix16[7:0] : w_pix16[15:8]);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vsync_out       <= 1'b0;
            href_out        <= 1'b0;
            pixel_out       <= 8'h00;
            frame_done_out  <= 1'b0;
            frame_count_out <= 8'h00;
            r_mode          <= 2'd0;
            r_color         <= 16'h0000;
        end else begin
            frame_done_out <= w_done;
            if (w_fall) begin
                vsync_out <= (w_state_nxt == VSYNC);
                href_out  <= w_href_nxt;
                pixel_out <= w_byte_nxt;
            end
            if (w_done) begin
                frame_count_out <= frame_count_out + 8'd1;
            end
            if (w_latch) begin
                r_mode  <= mode_in;
                r_color <= solid_color_in;
            end
        end
    end

endmodule

// File: tb/tb_camera_pattern_tx.sv
// tb/tb_camera_pattern_tx.sv - self-checking bench for camera_pattern_tx
module tb_camera_pattern_tx;

    localparam int PD = 1, HA = 8, HB = 4, VS = 1, VB = 1, VA = 2, VF = 1;
    localparam int LINE = 2 * HA + HB;
    localparam int FRAME_PCLK = LINE * (VS + VB + VA + VF);
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        enable_in = 1'b0;
    logic [1:0]  mode_in = 2'd0;
    logic [15:0] solid_color_in = 16'h0000;
    logic        pclk_out, vsync_out, href_out, frame_done_out;
    logic [7:0]  pixel_out, frame_count_out;

    int n_checks = 0, n_errors = 0, done_cnt = 0, done_bad = 0, exp_count = 0;
    logic       prev_href = 1'b0;
    logic [7:0] prev_count = 8'h00;

    always #5 clk_in = ~clk_in;

    camera_pattern_tx #(
        .PCLK_DIV(PD), .H_ACTIVE(HA), .H_BLANK(HB),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
        .mode_in(mode_in), .solid_color_in(solid_color_in),
        .pclk_out(pclk_out), .vsync_out(vsync_out), .href_out(href_out),
        .pixel_out(pixel_out), .frame_done_out(frame_done_out),
        .frame_count_out(frame_count_out)
    );

    // Each done pulse must coincide with href dropping and a count step.
    always @(negedge clk_in) begin
        if (frame_done_out) begin
            done_cnt <= done_cnt + 1;
            if (!(prev_href && !href_out && frame_count_out == 8'(prev_count + 8'd1)))
                done_bad <= done_bad + 1;
        end
        prev_href  <= href_out;
        prev_count <= frame_count_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pat_color(int mode, logic [15:0] color, int x, int y);
        int idx, gx;
        case (mode)
            0: begin
                idx = x / ((HA >= 8) ? HA / 8 : 1);
                if (idx > 7) idx = 7;
                return BARS[idx];
            end
            1: return color;
            2: begin
                gx = (x / 8) % 32;
                return 16'(gx * 2048 + ((y / 4) % 64) * 32 + (31 - gx));
            end
            default: return ((((x / 16) + (y / 16)) % 2) == 1) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    function automatic logic [9:0] exp_sample(int mode, logic [15:0] color, int s);
        int line, col;
        logic [15:0] p;
        line = s / LINE;
        col  = s % LINE;
        if (line < VS) return 10'h200;
        if (line < VS + VB || line >= VS + VB + VA || col >= 2 * HA) return 10'h000;
        p = pat_color(mode, color, col / 2, line - VS - VB);
        return {2'b01, (col % 2 == 0) ? p[15:8] : p[7:0]};
    endfunction

    task automatic next_rise();
        logic prev;
        bit   rose;
        rose = 1'b0;
        prev = pclk_out;
        for (int n = 0; n < 4 * PD + 4 && !rose; n++) begin
            @(posedge clk_in);
            #1;
            if (!prev && pclk_out) rose = 1'b1;
            prev = pclk_out;
        end
        if (!rose) chk("pclk_rise_timeout", 32'(rose), 32'd1);
    endtask

    task automatic wait_vsync();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            next_rise();
            if (vsync_out) seen = 1'b1;
        end
        if (!seen) chk("vsync_timeout", 32'(vsync_out), 32'd1);
    endtask

    task automatic check_frame(input bit first, input int mode, input logic [15:0] color,
                               input int nmode, input logic [15:0] ncolor, input bit drop_en);
        int d0;
        logic [9:0] obs, ex;
        d0 = done_cnt;
        for (int s = 0; s < FRAME_PCLK; s++) begin
            if (s > 0 || !first) next_rise();
            obs = {vsync_out, href_out, pixel_out};
            ex  = exp_sample(mode, color, s);
            chk($sformatf("stream m%0d l%0d c%0d", mode, s / LINE, s % LINE), 32'(obs), 32'(ex));
            if (s == 45 && drop_en) enable_in = 1'b0;
            if (s == 50) begin
                mode_in        = 2'(nmode);
                solid_color_in = ncolor;
            end
        end
        exp_count = (exp_count + 1) % 256;
        chk("frame_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("frame_count", 32'(frame_count_out), 32'(exp_count));
    endtask

    initial begin
        int cur_m, nxt_m, n, bad, d0;
        logic [15:0] cur_c, nxt_c;

        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_outputs", 32'({pclk_out, vsync_out, href_out, pixel_out, frame_done_out, frame_count_out}), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && !pclk_out; i++) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        chk("first_pclk_rise", 32'(n), 32'(PD));

        bad = 0;
        for (int i = 0; i < 20; i++) begin
            next_rise();
            if ({vsync_out, href_out, pixel_out, frame_count_out} != 0) bad++;
        end
        chk("idle_quiet_after_reset", 32'(bad), 32'd0);

        cur_m = 1;
        cur_c = 16'hABCD;
        mode_in = 2'd1;
        solid_color_in = cur_c;
        enable_in = 1'b1;
        wait_vsync();
        nxt_m = 0;
        nxt_c = 16'($urandom);
        check_frame(1'b1, cur_m, cur_c, nxt_m, nxt_c, 1'b0);
        cur_m = nxt_m;
        cur_c = nxt_c;
        for (int i = 0; i < 5; i++) begin
            nxt_m = int'($urandom_range(0, 3));
            nxt_c = 16'($urandom);
            check_frame(1'b0, cur_m, cur_c, nxt_m, nxt_c, 1'b0);
            cur_m = nxt_m;
            cur_c = nxt_c;
        end

        check_frame(1'b0, cur_m, cur_c, cur_m, cur_c, 1'b1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            next_rise();
            if ({vsync_out, href_out, pixel_out} != 0) bad++;
        end
        chk("idle_after_disable", 32'(bad), 32'd0);
        chk("count_held_in_idle", 32'(frame_count_out), 32'(exp_count));

        nxt_c = 16'($urandom);
        mode_in = 2'd1;
        solid_color_in = nxt_c;
        enable_in = 1'b1;
        wait_vsync();
        repeat (44) next_rise();
        #2;
        rst_in = 1'b0;
        #1;
        chk("reset_async_mid_active", 32'({pclk_out, vsync_out, href_out, pixel_out, frame_done_out, frame_count_out}), 32'd0);
        exp_count = 0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        n = 0;
        for (int i = 0; i < 10 && !vsync_out; i++) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        chk("vsync_after_release", 32'(n), 32'(2 * PD));
        check_frame(1'b0, 1, nxt_c, 1, nxt_c, 1'b0);

        d0 = done_cnt;
        for (int i = 0; i < 255 * FRAME_PCLK; i++) next_rise();
        chk("done_pulses_255_frames", 32'(done_cnt - d0), 32'd255);
        chk("frame_count_wrap", 32'(frame_count_out), 32'd0);
        chk("done_alignment", 32'(done_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/camera_pattern_tx.md
CAMERA_PATTERN_TX -- requirements
Module: camera_pattern_tx

Interface
REQ-001 The block SHALL have parameter PCLK_DIV, default 2, giving clk_in cycles per pclk_out half-period.
REQ-002 The block SHALL have parameter H_ACTIVE, default 320, giving pixels per active line.
REQ-003 The block SHALL have parameter H_BLANK, default 144, giving pclk cycles with href low per line.
REQ-004 The block SHALL have parameters V_SYNC, V_BACK, V_ACTIVE and V_FRONT, defaults 3, 17, 240 and 10, giving line counts per frame phase.
REQ-005 The block SHALL have port clk_in, input, 1 bit: the single system clock.
REQ-006 The block SHALL have port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port enable_in, input, 1 bit: run frames while high.
REQ-008 The block SHALL have port mode_in, input, 2 bits: pattern select.
REQ-009 The block SHALL have port solid_color_in, input, 16 bits: RGB565 colour for the solid pattern.
REQ-010 The block SHALL have port pclk_out, output, 1 bit: emulated camera pixel clock.
REQ-011 The block SHALL have port vsync_out, output, 1 bit: active-high frame sync.
REQ-012 The block SHALL have port href_out, output, 1 bit: active-high line-valid.
REQ-013 The block SHALL have port pixel_out, output, 8 bits: camera data byte.
REQ-014 The block SHALL have port frame_done_out, output, 1 bit: one-clk_in pulse at end of frame.
REQ-015 The block SHALL have port frame_count_out, output, 8 bits: completed frame count.

Function
REQ-016 The block SHALL emit an OV7670-style RGB565 stream that camera_read accepts unmodified.
REQ-017 pclk_out SHALL toggle every PCLK_DIV clk_in cycles, free-running from reset release; pclk_out first rises PCLK_DIV cycles after release.
REQ-018 vsync_out, href_out and pixel_out SHALL be registered and change only on the clk_in edge where pclk_out falls, so they are stable at every pclk_out rising edge.
REQ-019 The block SHALL use states IDLE, VSYNC, VBACK, ACTIVE and VFRONT; each line is 2*H_ACTIVE+H_BLANK pclk cycles.
REQ-020 IDLE SHALL go to VSYNC at a pclk falling edge where enable_in=1; mode_in and solid_color_in SHALL be latched at that edge and held for the frame.
REQ-021 VSYNC SHALL hold vsync_out=1 for V_SYNC lines, then go to VBACK, which SHALL last V_BACK lines with vsync_out=0 and href_out=0.
REQ-022 ACTIVE SHALL last V_ACTIVE lines: href_out=1 for the first 2*H_ACTIVE pclk cycles of each line, then 0 for H_BLANK cycles.
REQ-023 During each pixel, byte 0 SHALL be pixel[15:8] and byte 1 SHALL be pixel[7:0]; pixel_out SHALL be 0 whenever href_out=0.
REQ-024 VFRONT SHALL last V_FRONT lines, then the FSM SHALL return to VSYNC if enable_in=1, or to IDLE otherwise; this is the only point where enable_in is sampled.
REQ-025 Deasserting enable_in mid-frame SHALL NOT truncate the frame.
REQ-026 Pattern mode 0 SHALL be 8 colour bars, each H_ACTIVE/8 pixels wide, in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-027 Pattern mode 1 SHALL output the latched solid_color_in.
REQ-028 Pattern mode 2 SHALL be a gradient: {x[7:3], y[7:2], ~x[7:3]}, with x as pixel column and y as active row, both 0-based.
REQ-029 Pattern mode 3 SHALL be a checkerboard: FFFF when x[4]^y[4]=1, else 0000.
REQ-030 frame_done_out SHALL pulse high for exactly one clk_in cycle, on the pclk falling edge where href_out drops on the last ACTIVE line.
REQ-031 frame_count_out SHALL increment on the same cycle as frame_done_out and wrap from 255 to 0.
REQ-032 All line, pixel and byte counters SHALL wrap to 0 at their phase boundaries with no dead cycles.

Reset
REQ-033 rst_in=0 SHALL immediately, without a clock, force the FSM to IDLE, all counters to 0, and pclk_out, vsync_out, href_out, pixel_out, frame_done_out and frame_count_out to 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame; after release, no output SHALL change except pclk_out until enable_in is seen in IDLE.

Verification
REQ-035 With PCLK_DIV=1, H_ACTIVE=8, H_BLANK=4, V_SYNC=1, V_BACK=1, V_ACTIVE=2, V_FRONT=1, mode 1, colour 0xABCD and enable held high, each line SHALL be 20 pclk, vsync_out SHALL be high for 20 pclk, each active line SHALL be 16 href pclk then 4 low, and the bytes SHALL be AB,CD repeated 8 times.
REQ-036 With the same parameters in mode 0, the bytes per line SHALL be FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00.
REQ-037 Deasserting enable_in during the first ACTIVE line SHALL still complete the frame, produce one frame_done_out pulse, take frame_count_out from 0 to 1, then enter IDLE with no further vsync_out.
REQ-038 Changing mode_in from 1 to 0 mid-frame SHALL leave the current frame solid and make the next frame colour bars.
REQ-039 Driving rst_in low during ACTIVE SHALL force all outputs to 0 within the same cycle, and after release with enable_in=1 vsync_out SHALL rise at the first pclk falling edge.
REQ-040 After 256 frames, frame_count_out SHALL read 0, and each frame SHALL produce exactly one frame_done_out pulse.
